// File: rtl/lock_key_byte_loader.sv
// lock_key_byte_loader
// Provisioning end of an XOR key-locking interface. A secret key arrives as a
// byte stream (MSB byte first) over a valid/ready handshake, followed by one
// checksum byte. The frame is accepted when the XOR of all bytes is zero.
// The key bus feeding the locked datapath holds KEY_DEFAULT until a verified
// key is present. key_o never shows a partially assembled key.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   8      key/checksum byte
//   in_valid   in   1      in_data valid
//   in_ready   out  1      loader accepts a byte (xfer = in_valid & in_ready)
//   clear_i    in   1      one-cycle pulse: leave ERROR, return to IDLE
//   key_o      out  KEY_W  key bus to the locked datapath's keyinput
//   key_valid  out  1      key_o holds a verified key
//   key_error  out  1      sticky checksum/timeout failure since last clear
//
// Build option
//   KEY_LOADER_RELOAD_EN : when defined, a verified key may be replaced by a
//   new frame while the old key stays on key_o. When undefined, the key is
//   write-once until reset.
module lock_key_byte_loader #(
  parameter int unsigned      KEY_W       = 64,
  parameter logic [KEY_W-1:0] KEY_DEFAULT = '0,
  parameter int unsigned      TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid,
  output logic             key_error
);

  localparam int unsigned NB    = KEY_W / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);
  localparam int unsigned TMO_W = 16;

  // cnt value when the next byte is the checksum byte
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB);
  // timeout counter value at which a further idle cycle expires the frame
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

`ifdef KEY_LOADER_RELOAD_EN
  localparam logic DONE_READY = 1'b1;
`else
  localparam logic DONE_READY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] shadow;
  logic [7:0]       chk;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             xfer;

  assign xfer = in_valid & in_ready;

  // Loader FSM with registered handshake and key outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      key_o     <= KEY_DEFAULT;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      in_ready  <= 1'b1;
      shadow    <= '0;
      chk       <= 8'h00;
      cnt       <= '0;
      tmo       <= '0;
    end else begin
      case (state)
        // First key byte starts a fresh frame
        S_IDLE: begin
          if (xfer) begin
            shadow <= KEY_W'(in_data);
            chk    <= in_data;
            cnt    <= CNT_W'(1);
            tmo    <= '0;
            state  <= S_LOAD;
          end
        end

        // Key bytes are shifted in; the checksum byte only folds into chk
        S_LOAD: begin
          if (xfer) begin
            tmo <= '0;
            chk <= chk ^ in_data;
            if (cnt == CNT_LAST) begin
              in_ready <= 1'b0;
              state    <= S_CHECK;
            end else begin
              shadow <= (shadow << 8) | KEY_W'(in_data);
              cnt    <= cnt + CNT_W'(1);
            end
          end else if (tmo == TMO_LAST) begin
            key_error <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_ERROR;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        // Publish the assembled key atomically only if the frame checks out
        S_CHECK: begin
          if (chk == 8'h00) begin
            key_o     <= shadow;
            key_valid <= 1'b1;
            in_ready  <= DONE_READY;
            state     <= S_DONE;
          end else begin
            key_error <= 1'b1;
            state     <= S_ERROR;
          end
        end

        // Key held; a reload frame builds in shadow while key_o stays put
        S_DONE: begin
`ifdef KEY_LOADER_RELOAD_EN
          if (xfer) begin
            shadow <= KEY_W'(in_data);
            chk    <= in_data;
            cnt    <= CNT_W'(1);
            tmo    <= '0;
            state  <= S_LOAD;
          end
`endif
        end

        // Parked until software acknowledges the failure
        S_ERROR: begin
          if (clear_i) begin
            key_error <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
